// File: rtl/shift_reg_rs.sv
// Universal WIDTH-bit shift register with sync reset/set, enable and 3-bit mode select.
// Define SHIFT_REG_ROTATE_EN to enable rotate modes 100/101; otherwise they hold.
module shift_reg_rs #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             zero
);

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeShl  = 3'b001;
    localparam logic [2:0] ModeShr  = 3'b010;
    localparam logic [2:0] ModeLoad = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeRor  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shl, shr, asr;
`ifdef SHIFT_REG_ROTATE_EN
    logic [WIDTH-1:0] rol, ror;
`endif

    // A 1-bit register has no bits to move, so rotate and arithmetic shift degrade to hold.
    if (WIDTH == 1) begin : g_w1
        assign shl = si_r;
        assign shr = si_l;
        assign asr = q_q;
`ifdef SHIFT_REG_ROTATE_EN
        assign rol = q_q;
        assign ror = q_q;
`endif
    end else begin : g_wn
        assign shl = {q_q[WIDTH-2:0], si_r};
        assign shr = {si_l, q_q[WIDTH-1:1]};
        assign asr = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
        assign rol = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        assign ror = {q_q[0], q_q[WIDTH-1:1]};
`endif
    end

    always_comb begin
        q_d = q_q;
        if (!set_n) begin
            q_d = {WIDTH{1'b1}};
        end else if (en) begin
            case (mode)
                ModeHold: q_d = q_q;
                ModeShl:  q_d = shl;
                ModeShr:  q_d = shr;
                ModeLoad: q_d = d;
`ifdef SHIFT_REG_ROTATE_EN
                ModeRol:  q_d = rol;
                ModeRor:  q_d = ror;
`else
                ModeRol:  q_d = q_q;
                ModeRor:  q_d = q_q;
`endif
                ModeAsr:  q_d = asr;
                default:  q_d = q_q;
            endcase
        end
    end

    // Reset sits above set_n and en in priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign so_l = q_q[WIDTH-1];
    assign so_r = q_q[0];
    assign zero = (q_q == {WIDTH{1'b0}});

endmodule
